score_overlay: RTL

- Tile-grid renderer for the Pong game's on-screen scores and centre net.
- Takes the same 6-bit divided column/row counts (40x30 tiles of 16x16 px) that feed the ball and paddle blocks, plus both players' point counts.
- Produces a registered draw flag that is ORed with the ball/paddle draw flags ahead of vga_sync_porch.
- Latches scores once per frame, so digits never tear mid-frame.
- Flashes the winner's digit for a fixed number of frames after a match win.

---
 rtl/score_overlay.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/score_overlay.sv
// score_overlay: tile-grid renderer for the Pong scores and dashed centre net.
// Scores are latched once per frame; the winner's digit blinks during the win flash.
`default_nettype none

module score_overlay #(
  parameter int DIGIT_Y      = 1,
  parameter int DIGIT1_X     = 16,
  parameter int DIGIT2_X     = 21,
  parameter int NET_X        = 19,
  parameter int NET_EN       = 1,
  parameter int BLINK_FRAMES = 15,
  parameter int FLASH_FRAMES = 120
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ivsync,
  input  logic [5:0] icolcount,
  input  logic [5:0] irowcount,
  input  logic [4:0] ip1points,
  input  logic [4:0] ip2points,
  input  logic [1:0] iwin,
  output logic       odrawscore,
  output logic       oflashing
);

  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES + 1) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [FW-1:0] FLAST  = FW'(FLASH_FRAMES - 1);
  localparam logic [BW-1:0] BLAST  = BW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    DY     = 7'(DIGIT_Y);
  localparam logic [6:0]    D1X    = 7'(DIGIT1_X);
  localparam logic [6:0]    D2X    = 7'(DIGIT2_X);
  localparam logic [5:0]    NETX   = 6'(NET_X);
  localparam logic          NET_ON = (NET_EN != 0);

  typedef enum logic {SHOW = 1'b0, FLASH = 1'b1} state_t;

  state_t        state;
  logic          vsync_d;
  logic [3:0]    s1;
  logic [3:0]    s2;
  logic          winner_p2;
  logic          hidden;
  logic [FW-1:0] frame_cnt;
  logic [BW-1:0] blink_cnt;

  logic       frame_start;
  logic [6:0] col7;
  logic [6:0] row7;
  logic       active;
  logic       hit1;
  logic       hit2;
  logic       hit_net;
  logic [1:0] dx1;
  logic [1:0] dx2;
  logic [2:0] dy;
  logic       hide1;
  logic       hide2;
  logic       draw_next;

  // 3x5 glyphs, row 0 in bits [14:12], MSB of each row is the leftmost tile
  function automatic logic [14:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 15'b111_101_101_101_111;
      4'd1:    glyph = 15'b001_001_001_001_001;
      4'd2:    glyph = 15'b111_001_111_100_111;
      4'd3:    glyph = 15'b111_001_111_001_111;
      4'd4:    glyph = 15'b101_101_111_001_001;
      4'd5:    glyph = 15'b111_100_111_001_111;
      4'd6:    glyph = 15'b111_100_111_101_111;
      4'd7:    glyph = 15'b111_001_001_001_001;
      4'd8:    glyph = 15'b111_101_111_101_111;
      4'd9:    glyph = 15'b111_101_111_001_111;
      default: glyph = 15'b0;
    endcase
  endfunction

  function automatic logic glyph_lit(input logic [3:0] d, input logic [2:0] r,
                                     input logic [1:0] c);
    logic [14:0] g;
    logic [2:0]  rb;
    g = glyph(d);
    case (r)
      3'd0:    rb = g[14:12];
      3'd1:    rb = g[11:9];
      3'd2:    rb = g[8:6];
      3'd3:    rb = g[5:3];
      3'd4:    rb = g[2:0];
      default: rb = 3'b000;
    endcase
    case (c)
      2'd0:    glyph_lit = rb[2];
      2'd1:    glyph_lit = rb[1];
      2'd2:    glyph_lit = rb[0];
      default: glyph_lit = 1'b0;
    endcase
  endfunction

  assign frame_start = vsync_d & ~ivsync;

  always_comb begin
    col7    = {1'b0, icolcount};
    row7    = {1'b0, irowcount};
    active  = (icolcount < 6'd40) && (irowcount < 6'd30);
    // offsets are only used inside the hit window, so modulo arithmetic suffices
    dx1     = icolcount[1:0] - D1X[1:0];
    dx2     = icolcount[1:0] - D2X[1:0];
    dy      = irowcount[2:0] - DY[2:0];
    hit1    = (col7 >= D1X) && (col7 <= D1X + 7'd2) && (row7 >= DY) && (row7 <= DY + 7'd4);
    hit2    = (col7 >= D2X) && (col7 <= D2X + 7'd2) && (row7 >= DY) && (row7 <= DY + 7'd4);
    hit_net = NET_ON && (icolcount == NETX) && !irowcount[0];
    hide1   = (state == FLASH) && hidden && !winner_p2;
    hide2   = (state == FLASH) && hidden && winner_p2;
    draw_next = active && ((hit1 && !hide1 && glyph_lit(s1, dy, dx1)) ||
                           (hit2 && !hide2 && glyph_lit(s2, dy, dx2)) ||
                           hit_net);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SHOW;
      vsync_d    <= 1'b1;
      s1         <= 4'd0;
      s2         <= 4'd0;
      winner_p2  <= 1'b0;
      hidden     <= 1'b0;
      frame_cnt  <= '0;
      blink_cnt  <= '0;
      odrawscore <= 1'b0;
      oflashing  <= 1'b0;
    end else begin
      vsync_d    <= ivsync;
      odrawscore <= draw_next;
      if (frame_start) begin
        s1 <= (ip1points > 5'd9) ? 4'd9 : ip1points[3:0];
        s2 <= (ip2points > 5'd9) ? 4'd9 : ip2points[3:0];
      end
      // a win pulse always (re)starts the flash and swallows a coincident frame start
      if (iwin != 2'b00) begin
        state     <= FLASH;
        oflashing <= 1'b1;
        winner_p2 <= ~iwin[0];
        hidden    <= 1'b0;
        frame_cnt <= '0;
        blink_cnt <= '0;
      end else if (state == FLASH && frame_start) begin
        if (frame_cnt == FLAST) begin
          state     <= SHOW;
          oflashing <= 1'b0;
          hidden    <= 1'b0;
          frame_cnt <= '0;
          blink_cnt <= '0;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
          if (blink_cnt == BLAST) begin
            blink_cnt <= '0;
            hidden    <= ~hidden;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
